// File: rtl/dbus_arbiter_pkg.sv
// Data-bus request/response types and the arbiter's shared constants.
// Widths of owner/ptr fields come from idx_w so a single requester still gets a 1-bit index.
package dbus_arbiter_pkg;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef logic [7:0] strobe_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    strobe_t     strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  localparam int DBUS_NREQ = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } dbus_arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dbus_arbiter_if.sv
// Requester-facing and downstream data-bus signals of the arbiter.
// The arbiter uses the slave view; whoever drives requests and the downstream bus uses master.
interface dbus_arbiter_if #(
  parameter int NREQ = dbus_arbiter_pkg::DBUS_NREQ
);
  import dbus_arbiter_pkg::*;

  dbus_req_t  req  [NREQ];
  dbus_resp_t resp [NREQ];
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport slave  (input req, input dresp, output resp, output dreq);
  modport master (output req, output dresp, input resp, input dreq);

endinterface

// File: rtl/dbus_arbiter_rr_pick.sv
// Combinational priority picker: first valid index scanning from ptr (rotating) or from 0 (fixed).
module dbus_arbiter_rr_pick #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  input  logic         rr_en_i,
  output logic [W-1:0] grant_o,
  output logic         any_o
);

  always_comb begin
    int         idx;
    logic [W-1:0] idx_b;
    idx     = 0;
    idx_b   = '0;
    grant_o = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = rr_en_i ? int'(ptr_i) + k : k;
      if (idx >= N) idx = idx - N;
      idx_b = W'(idx);
      if (!any_o && valid_i[idx_b]) begin
        any_o   = 1'b1;
        grant_o = idx_b;
      end
    end
  end

endmodule

// File: rtl/dbus_arbiter.sv
// Shares one data-bus port among NREQ requesters: grants one, holds its request until
// data_ok, and delivers data_ok only to a still-present owner.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
#(
  parameter int  NREQ        = DBUS_NREQ,
  parameter bit  ROUND_ROBIN = 1'b1,
  localparam int W           = idx_w(NREQ)
) (
  input  logic           clk,
  input  logic           reset,
  dbus_arbiter_if.slave  bus,
  output logic           busy,
  output logic [W-1:0]   owner
);

  dbus_arb_state_t state_q, state_d;
  logic [W-1:0]    owner_q, owner_d;
  logic [W-1:0]    ptr_q, ptr_d;
  dbus_req_t       lreq_q, lreq_d;
  logic            owner_live_q, owner_live_d;

  logic [NREQ-1:0] valid_vec;
  logic [NREQ-1:0] ok_vec;
  logic [W-1:0]    grant;
  logic            grant_any;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_port
    assign valid_vec[gi] = bus.req[gi].valid;
    // Data is broadcast; only the owner's data_ok qualifies it.
    assign bus.resp[gi]  = '{data_ok: ok_vec[gi], data: bus.dresp.data};
  end

  dbus_arbiter_rr_pick #(
    .N (NREQ),
    .W (W)
  ) u_pick (
    .valid_i (valid_vec),
    .ptr_i   (ptr_q),
    .rr_en_i (ROUND_ROBIN),
    .grant_o (grant),
    .any_o   (grant_any)
  );

  function automatic logic [W-1:0] wrap_inc(input logic [W-1:0] x);
    return (int'(x) >= NREQ - 1) ? '0 : x + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      lreq_q       <= '0;
      owner_live_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      lreq_q       <= lreq_d;
      owner_live_q <= owner_live_d;
    end
  end

  // The rotation pointer moves only on completion, so a waiting requester is reached within NREQ transactions.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    lreq_d       = lreq_q;
    owner_live_d = owner_live_q;
    case (state_q)
      ARB_IDLE: begin
        if (grant_any) begin
          owner_d = grant;
          if (bus.dresp.data_ok) begin
            ptr_d = wrap_inc(grant);
          end else begin
            state_d      = ARB_BUSY;
            lreq_d       = bus.req[grant];
            owner_live_d = 1'b1;
          end
        end
      end
      ARB_BUSY: begin
        if (!bus.req[owner_q].valid) owner_live_d = 1'b0;
        if (bus.dresp.data_ok) begin
          state_d      = ARB_IDLE;
          ptr_d        = wrap_inc(owner_q);
          lreq_d.valid = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // A flushed owner never sees the late response; the downstream transaction still completes.
  always_comb begin
    bus.dreq = '0;
    ok_vec   = '0;
    busy     = 1'b0;
    if (reset) begin
      if (state_q == ARB_BUSY) begin
        busy            = 1'b1;
        bus.dreq        = lreq_q;
        ok_vec[owner_q] = bus.dresp.data_ok & owner_live_q & bus.req[owner_q].valid;
      end else if (grant_any) begin
        bus.dreq      = bus.req[grant];
        ok_vec[grant] = bus.dresp.data_ok;
      end
    end
  end

  assign owner = owner_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: fixed-priority and round-robin instances share stimulus; directed
// scenarios then random traffic, every cycle compared against a transaction-level model.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  localparam int N = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dbus_req_t  req [N];
  dbus_resp_t dresp;

  dbus_arbiter_if #(.NREQ(N)) bus_fx ();
  dbus_arbiter_if #(.NREQ(N)) bus_rr ();
  logic       busy_fx, busy_rr;
  logic [1:0] owner_fx, owner_rr;

  for (genvar gi = 0; gi < N; gi++) begin : g_drive
    assign bus_fx.req[gi] = req[gi];
    assign bus_rr.req[gi] = req[gi];
  end
  assign bus_fx.dresp = dresp;
  assign bus_rr.dresp = dresp;

  dbus_arbiter #(.NREQ(N), .ROUND_ROBIN(1'b0)) dut_fx (
    .clk(clk), .reset(reset), .bus(bus_fx), .busy(busy_fx), .owner(owner_fx)
  );
  dbus_arbiter #(.NREQ(N), .ROUND_ROBIN(1'b1)) dut_rr (
    .clk(clk), .reset(reset), .bus(bus_rr), .busy(busy_rr), .owner(owner_rr)
  );

  int n_err = 0;
  int n_chk = 0;

  // Model, index 0 = fixed priority, 1 = round robin.
  int           m_cur   [2];  // requester with an outstanding downstream transaction, -1 if none
  int           m_owner [2];
  int           m_ptr   [2];
  bit           m_live  [2];
  dbus_req_t    m_held  [2];
  logic [N-1:0] exp_ok  [2];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int m);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (m == 1) ? (m_ptr[m] + k) % N : k;
      if (req[i].valid) return i;
    end
    return -1;
  endfunction

  task automatic check_cycle(string tag);
    for (int m = 0; m < 2; m++) begin
      dbus_req_t    e_dreq, o_dreq;
      logic [N-1:0] e_ok, o_ok;
      logic         o_busy;
      logic [1:0]   o_owner;
      logic [63:0]  o_data;
      int           g;
      string        p;
      p      = $sformatf("%s/%s", tag, (m == 1) ? "rr" : "fx");
      e_dreq = '0;
      e_ok   = '0;
      if (reset) begin
        if (m_cur[m] >= 0) begin
          e_dreq = m_held[m];
          if (dresp.data_ok && m_live[m] && req[m_cur[m]].valid) e_ok[m_cur[m]] = 1'b1;
        end else begin
          g = pick(m);
          if (g >= 0) begin
            e_dreq  = req[g];
            e_ok[g] = dresp.data_ok;
          end
        end
      end
      exp_ok[m] = e_ok;
      o_dreq  = (m == 1) ? bus_rr.dreq : bus_fx.dreq;
      o_busy  = (m == 1) ? busy_rr : busy_fx;
      o_owner = (m == 1) ? owner_rr : owner_fx;
      o_data  = (m == 1) ? bus_rr.resp[N-1].data : bus_fx.resp[N-1].data;
      for (int i = 0; i < N; i++)
        o_ok[i] = (m == 1) ? bus_rr.resp[i].data_ok : bus_fx.resp[i].data_ok;
      chk({p, "_dvalid"}, 64'(o_dreq.valid), 64'(e_dreq.valid));
      if (e_dreq.valid) begin
        chk({p, "_daddr"}, o_dreq.addr, e_dreq.addr);
        chk({p, "_dstrb"}, 64'(o_dreq.strobe), 64'(e_dreq.strobe));
        chk({p, "_dsize"}, 64'(o_dreq.size), 64'(e_dreq.size));
        chk({p, "_ddata"}, o_dreq.data, e_dreq.data);
      end
      chk({p, "_busy"}, 64'(o_busy), 64'(reset && (m_cur[m] >= 0)));
      chk({p, "_owner"}, 64'(o_owner), 64'(m_owner[m]));
      chk({p, "_ok"}, 64'(o_ok), 64'(e_ok));
      chk({p, "_rdata"}, o_data, dresp.data);
    end
  endtask

  task automatic model_update();
    for (int m = 0; m < 2; m++) begin
      int g;
      if (!reset) begin
        m_cur[m] = -1; m_owner[m] = 0; m_ptr[m] = 0; m_live[m] = 1'b0;
      end else if (m_cur[m] < 0) begin
        g = pick(m);
        if (g >= 0) begin
          m_owner[m] = g;
          if (dresp.data_ok) m_ptr[m] = (g + 1) % N;
          else begin
            m_cur[m] = g; m_held[m] = req[g]; m_live[m] = 1'b1;
          end
        end
      end else begin
        if (!req[m_cur[m]].valid) m_live[m] = 1'b0;
        if (dresp.data_ok) begin
          m_ptr[m] = (m_cur[m] + 1) % N;
          m_cur[m] = -1;
        end
      end
    end
  endtask

  task automatic step(string tag);
    @(negedge clk);
    check_cycle(tag);
    model_update();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int i, bit v, logic [63:0] a, msize_t sz, strobe_t st);
    req[i].valid  = v;
    req[i].addr   = a;
    req[i].size   = sz;
    req[i].strobe = st;
    req[i].data   = {a[31:0], ~a[31:0]};
  endtask

  task automatic do_reset();
    reset = 1'b0;
    dresp = '0;
    for (int i = 0; i < N; i++) req[i] = '0;
    step("rst");
    adv();
    reset = 1'b1;
  endtask

  initial begin
    int          pulses;
    logic [63:0] got_data;
    int          rr_order [4];
    logic [2:0]  okv;
    rr_order = '{0, 1, 2, 0};
    for (int i = 0; i < N; i++) req[i] = '0;
    dresp = '0;
    for (int m = 0; m < 2; m++) begin
      m_cur[m] = -1; m_owner[m] = 0; m_ptr[m] = 0; m_live[m] = 1'b0;
      m_held[m] = '0; exp_ok[m] = '0;
    end

    // Reset state
    adv();
    step("rst0"); adv();
    step("rst1");
    chk("rst_busy", 64'(busy_rr), 64'(0));
    chk("rst_dvalid", 64'(bus_rr.dreq.valid), 64'(0));
    adv();
    reset = 1'b1;
    step("idle"); adv();

    // Single requester, response three cycles after grant
    set_req(1, 1'b1, 64'h8000_0010, MSIZE8, 8'h00);
    pulses   = 0;
    got_data = '0;
    for (int c = 0; c < 4; c++) begin
      dresp.data_ok = (c == 3);
      dresp.data    = (c == 3) ? 64'h1122_3344_5566_7788 : 64'h0;
      step("single");
      chk("single_addr", bus_rr.dreq.addr, 64'h8000_0010);
      chk("single_other_ok", 64'({bus_rr.resp[2].data_ok, bus_rr.resp[0].data_ok}), 64'(0));
      if (bus_rr.resp[1].data_ok) begin
        pulses++;
        got_data = bus_rr.resp[1].data;
      end
      adv();
    end
    req[1].valid = 1'b0;
    dresp        = '0;
    chk("single_pulses", 64'(pulses), 64'(1));
    chk("single_data", got_data, 64'h1122_3344_5566_7788);

    // All three requesting, two cycles per transaction
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 64'h1000 + 64'(i) * 8, MSIZE8, 8'hFF);
    for (int c = 0; c < 8; c++) begin
      dresp.data_ok = c[0];
      dresp.data    = 64'(c) * 64'h0101;
      step("rr3");
      if (c[0]) begin
        chk("rr_order", 64'(owner_rr), 64'(rr_order[c / 2]));
        chk("fx_order", 64'(owner_fx), 64'(0));
      end
      adv();
    end

    // Owner withdraws while busy
    do_reset();
    set_req(2, 1'b1, 64'h100, MSIZE8, 8'hFF);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) req[2].valid = 1'b0;
      dresp.data_ok = (c == 4);
      dresp.data    = 64'hA5A5_0000 + 64'(c);
      step("flush");
      if (c >= 2 && c <= 4) begin
        chk("flush_addr", bus_rr.dreq.addr, 64'h100);
        chk("flush_strb", 64'(bus_rr.dreq.strobe), 64'hFF);
        chk("flush_r2ok", 64'(bus_rr.resp[2].data_ok), 64'(0));
      end
      if (c == 5) chk("flush_idle", 64'(busy_rr), 64'(0));
      adv();
    end

    // Zero-latency bus, two requesters
    do_reset();
    set_req(0, 1'b1, 64'h200, MSIZE4, 8'h0F);
    set_req(1, 1'b1, 64'h300, MSIZE4, 8'hF0);
    dresp.data_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      dresp.data = {$urandom, $urandom};
      step("zl");
      chk("zl_busy", 64'(busy_rr), 64'(0));
      chk("zl_grant_ok", 64'(bus_rr.resp[c % 2].data_ok), 64'(1));
      if (c > 0) chk("zl_owner", 64'(owner_rr), 64'((c - 1) % 2));
      adv();
    end

    // Reset while busy, then a late data_ok
    do_reset();
    set_req(0, 1'b1, 64'h400, MSIZE4, 8'h0F);
    step("rb_grant"); adv();
    step("rb_busy");
    chk("rb_busy", 64'(busy_rr), 64'(1));
    adv();
    reset        = 1'b0;
    req[0].valid = 1'b0;
    step("rb_rst"); adv();
    reset         = 1'b1;
    dresp.data_ok = 1'b1;
    dresp.data    = 64'hDEAD_BEEF_0000_0001;
    step("rb_late");
    okv = {bus_rr.resp[2].data_ok, bus_rr.resp[1].data_ok, bus_rr.resp[0].data_ok};
    chk("rb_late_busy", 64'(busy_rr), 64'(0));
    chk("rb_late_dvalid", 64'(bus_rr.dreq.valid), 64'(0));
    chk("rb_late_ok", 64'(okv), 64'(0));
    adv();
    dresp.data_ok = 1'b0;
    step("rb_after"); adv();

    // New request arriving with another requester's data_ok
    do_reset();
    set_req(1, 1'b1, 64'h500, MSIZE8, 8'hFF);
    step("nr_grant"); adv();
    dresp.data_ok = 1'b1;
    set_req(0, 1'b1, 64'h600, MSIZE8, 8'h3C);
    step("nr_done");
    chk("nr_same_addr", bus_rr.dreq.addr, 64'h500);
    chk("nr_r0_ok", 64'(bus_rr.resp[0].data_ok), 64'(0));
    chk("nr_r1_ok", 64'(bus_rr.resp[1].data_ok), 64'(1));
    adv();
    req[1].valid  = 1'b0;
    dresp.data_ok = 1'b0;
    step("nr_next");
    chk("nr_next_addr", bus_rr.dreq.addr, 64'h600);
    adv();
    step("nr_busy");
    chk("nr_owner", 64'(owner_rr), 64'(0));
    adv();

    // Random traffic: requesters drop on their response or occasionally flush
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i].valid) begin
          if (exp_ok[1][i] || ($urandom_range(0, 49) == 0)) req[i].valid = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_req(i, 1'b1, {$urandom, $urandom} & ~64'h7,
                  msize_t'($urandom_range(0, 3)), strobe_t'($urandom_range(0, 255)));
        end
      end
      dresp.data_ok = ($urandom_range(0, 9) < 4);
      dresp.data    = {$urandom, $urandom};
      reset         = ($urandom_range(0, 99) != 0);
      step("rand");
      adv();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
